// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: one power-of-two stage (16,8,4,2,1) per cycle,
// logical left or arithmetic right, with a start/ready/done handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | ready for a new operation, ready=1
// ST_SHIFT | applying stage idx to acc, busy=1
// ST_DONE  | result valid, done pulses for one cycle
module shift_sequencer #(
    parameter int WIDTH  = 32,
    parameter int NSTAGE = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [NSTAGE-1:0] shamt,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] IDX_TOP = 3'(NSTAGE - 1);

    state_t              state_q,  state_d;
    logic [2:0]          idx_q,    idx_d;
    logic [WIDTH-1:0]    acc_q,    acc_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [NSTAGE-1:0]   shamt_q,  shamt_d;
    logic                op_q,     op_d;
    logic                ready_q,  ready_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic [WIDTH-1:0]    acc_stage;

    // Shift by 2^s; SRA replicates the current bit 31, which never changes under SRA.
    function automatic logic [31:0] stage_shift(
        input logic [31:0] a,
        input logic        sra,
        input logic [2:0]  s
    );
        logic [31:0] r;
        r = a;
        case (s)
            3'd4: r = sra ? {{16{a[31]}}, a[31:16]} : {a[15:0], 16'h0000};
            3'd3: r = sra ? {{8{a[31]}},  a[31:8]}  : {a[23:0], 8'h00};
            3'd2: r = sra ? {{4{a[31]}},  a[31:4]}  : {a[27:0], 4'h0};
            3'd1: r = sra ? {{2{a[31]}},  a[31:2]}  : {a[29:0], 2'b00};
            3'd0: r = sra ? {a[31],       a[31:1]}  : {a[30:0], 1'b0};
            default: r = a;
        endcase
        return r;
    endfunction

    always_comb begin
        acc_stage = acc_q;
        if (shamt_q[idx_q]) begin
            acc_stage = stage_shift(acc_q, op_q, idx_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        shamt_d  = shamt_q;
        op_d     = op_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = done_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = data_in;
                    op_d    = op;
                    shamt_d = shamt;
                    idx_d   = IDX_TOP;
                    state_d = ST_SHIFT;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    // Abort wins over the final stage: no result update, no done.
                    state_d = ST_IDLE;
                    idx_d   = IDX_TOP;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    acc_d = acc_stage;
                    if (idx_q == 3'd0) begin
                        result_d = acc_stage;
                        idx_d    = IDX_TOP;
                        state_d  = ST_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                ready_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = IDX_TOP;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= IDX_TOP;
            acc_q    <= '0;
            result_q <= '0;
            shamt_q  <= '0;
            op_q     <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            shamt_q  <= shamt_d;
            op_q     <= op_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed cases plus randomized
// operations checked against a plain arithmetic shift model.
module tb_shift_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] data_in = '0;
    logic [4:0]  shamt = '0;
    logic        ready, busy, done;
    logic [31:0] result;

    shift_sequencer #(.WIDTH(32), .NSTAGE(5)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .abort   (abort),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          dcyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] model(input logic o, input logic [31:0] d, input logic [4:0] s);
        if (o) return 32'($signed(d) >>> s);
        return d << s;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with result %h, expected no done", result);
            end else begin
                mon_e = sbq.pop_front();
                chk32("result", result, mon_e.res);
                chk_int("done_cycle", cyc, mon_e.dcyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge k.
    task automatic issue(input logic o, input logic [31:0] d, input logic [4:0] s,
                         input bit expect_done, output int k);
        bit got;
        exp_t e;
        got = 0;
        k = -1;
        for (int i = 0; i < 40; i++) begin
            if (ready === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clock);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b expected 1", ready);
            return;
        end
        op = o; data_in = d; shamt = s; start = 1'b1;
        k = cyc + 1;
        if (expect_done) begin
            e.res  = model(o, d, s);
            e.dcyc = k + 5;
            sbq.push_back(e);
        end
        @(negedge clock);
        start = 1'b0;
        data_in = $urandom;
        chk32("busy_after_accept", {31'b0, busy}, 32'd1);
        chk32("ready_after_accept", {31'b0, ready}, 32'd0);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (sbq.size() == 0 && ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    int          k;
    logic [31:0] prev;
    int          acc_cyc[$];

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk32("reset_ready", {31'b0, ready}, 32'd1);
        chk32("reset_busy", {31'b0, busy}, 32'd0);
        chk32("reset_done", {31'b0, done}, 32'd0);
        chk32("reset_result", result, 32'h0);

        issue(1'b1, 32'h80000000, 5'd16, 1, k); drain();
        chk32("sra16", result, 32'hFFFF8000);
        issue(1'b0, 32'h00000001, 5'd31, 1, k); drain();
        chk32("sll31", result, 32'h80000000);
        issue(1'b1, 32'h7FFFFFFF, 5'd31, 1, k); drain();
        chk32("sra31_pos", result, 32'h00000000);
        issue(1'b1, 32'hF0F0F0F0, 5'd5, 1, k); drain();
        chk32("sra5", result, 32'hFF878787);

        // shamt=0 with stray starts during SHIFT and DONE
        issue(1'b0, 32'h12345678, 5'd0, 1, k);
        @(negedge clock);
        data_in = 32'hAAAAAAAA; shamt = 5'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (cyc < k + 5) @(negedge clock);
        chk32("done_state_ready", {31'b0, ready}, 32'd0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        drain();
        chk32("shamt0", result, 32'h12345678);

        // abort sampled two edges after acceptance
        prev = result;
        issue(1'b0, 32'hDEADBEEF, 5'd4, 0, k);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk32("abort_ready", {31'b0, ready}, 32'd1);
        chk32("abort_busy", {31'b0, busy}, 32'd0);
        chk32("abort_result_held", result, prev);
        repeat (8) @(negedge clock);
        issue(1'b0, 32'hDEADBEEF, 5'd4, 1, k); drain();
        chk32("sll4", result, 32'hEADBEEF0);

        // asynchronous reset in the middle of SHIFT
        issue(1'b1, 32'h11111111, 5'd3, 1, k);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk32("async_rst_ready", {31'b0, ready}, 32'd1);
        chk32("async_rst_busy", {31'b0, busy}, 32'd0);
        chk32("async_rst_done", {31'b0, done}, 32'd0);
        chk32("async_rst_result", result, 32'h0);
        sbq.delete();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        issue(1'b1, 32'h80000001, 5'd1, 1, k); drain();
        chk32("sra1_after_rst", result, 32'hC0000000);

        // randomized operations, some aborted
        for (int n = 0; n < 25; n++) begin
            logic        ro;
            logic [31:0] rd;
            logic [4:0]  rs;
            bit          do_abort;
            int          dly;
            ro = 1'($urandom);
            rd = $urandom;
            rs = 5'($urandom);
            do_abort = ($urandom_range(0, 4) == 0);
            issue(ro, rd, rs, !do_abort, k);
            if (do_abort) begin
                dly = $urandom_range(0, 3);
                repeat (dly) @(negedge clock);
                abort = 1'b1;
                @(negedge clock);
                abort = 1'b0;
                chk32("rand_abort_ready", {31'b0, ready}, 32'd1);
            end
        end
        drain();

        // start held high: one acceptance every 7 cycles
        start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (ready === 1'b1) begin
                exp_t e;
                op = 1'($urandom);
                data_in = $urandom;
                shamt = 5'($urandom);
                e.res  = model(op, data_in, shamt);
                e.dcyc = cyc + 6;
                sbq.push_back(e);
                acc_cyc.push_back(cyc + 1);
            end
            @(negedge clock);
        end
        start = 1'b0;
        for (int i = 1; i < acc_cyc.size(); i++)
            chk_int("held_start_spacing", acc_cyc[i] - acc_cyc[i-1], 7);
        drain();
        repeat (5) @(negedge clock);
        chk_int("scoreboard_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
